// File: rtl/string_hw_pkg.sv
// Shared register map and bit positions for the string accelerator word FIFO.
package string_hw_pkg;
  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd1;
  localparam logic [2:0] ADDR_COUNT  = 3'd2;
  localparam logic [2:0] ADDR_CTRL   = 3'd3;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_UNDERFLOW = 3;

  localparam int CTRL_FLUSH = 0;
endpackage

// File: rtl/string_word_fifo.sv
// Synchronous word FIFO with flush; head word is presented combinationally on dout.
module string_word_fifo #(
  parameter  int DEPTH  = 8,
  parameter  int DATA_W = 32,
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = PW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // The Avalon decode never issues push and pop together, but keep count consistent if it did.
      if (do_push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; stale words are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/string_hw_avalon.sv
// Avalon-MM slave wrapper: register decode, zero-latency read mux and sticky error flags.
module string_hw_avalon
  import string_hw_pkg::*;
#(
  parameter  int DEPTH  = 8,
  parameter  int DATA_W = 32,
  localparam int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] writedata,
  input  logic [2:0]        address,
  output logic [DATA_W-1:0] readdata,
  input  logic              write,
  input  logic              read,
  input  logic              chipselect
);
  logic              wr_en, rd_en, rd_act;
  logic              push, pop, flush;
  logic [DATA_W-1:0] head;
  logic [CW-1:0]     count;
  logic              empty, full;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic [DATA_W-1:0] status;

  assign wr_en  = chipselect & write;
  assign rd_en  = chipselect & read;
  // A simultaneous write wins; the read then has no side effects.
  assign rd_act = rd_en & ~wr_en;

  assign push  = wr_en & (address == ADDR_DATA);
  assign pop   = rd_act & (address == ADDR_DATA);
  assign flush = wr_en & (address == ADDR_CTRL) & writedata[CTRL_FLUSH];

  string_word_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (writedata),
    .dout  (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push && full)  overflow_d  = 1'b1;
      if (pop && empty)  underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    status               = '0;
    status[ST_EMPTY]     = empty;
    status[ST_FULL]      = full;
    status[ST_OVERFLOW]  = overflow_q;
    status[ST_UNDERFLOW] = underflow_q;
  end

  always_comb begin
    readdata = '0;
    if (rd_en) begin
      case (address)
        ADDR_DATA:   readdata = empty ? '0 : head;
        ADDR_STATUS: readdata = status;
        ADDR_COUNT:  readdata = DATA_W'(count);
        default:     readdata = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_string_hw_avalon.sv
// Scoreboard bench: stimulus queues expected read data from a queue-based model; a negedge monitor compares.
module tb_string_hw_avalon;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] writedata = '0;
  logic [2:0]  address = '0;
  logic [31:0] readdata;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic        chipselect = 1'b0;

  always #5 clk = ~clk;

  string_hw_avalon #(.DEPTH(DEPTH), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .writedata  (writedata),
    .address    (address),
    .readdata   (readdata),
    .write      (write),
    .read       (read),
    .chipselect (chipselect)
  );

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int          pass_cnt = 0;
  int          tot_cnt  = 0;

  // Reference model: the FIFO is just a queue of words plus two sticky bits.
  logic [31:0] mdl_q[$];
  bit          mdl_ovf = 1'b0;
  bit          mdl_unf = 1'b0;

  function automatic logic [31:0] mdl_status();
    logic [31:0] s;
    s    = '0;
    s[0] = (mdl_q.size() == 0);
    s[1] = (mdl_q.size() == DEPTH);
    s[2] = mdl_ovf;
    s[3] = mdl_unf;
    return s;
  endfunction

  function automatic logic [31:0] mdl_read_value(input logic [2:0] a);
    case (a)
      3'd0:    return (mdl_q.size() > 0) ? mdl_q[0] : 32'd0;
      3'd1:    return mdl_status();
      3'd2:    return 32'(mdl_q.size());
      default: return 32'd0;
    endcase
  endfunction

  function automatic void mdl_clear();
    mdl_q.delete();
    mdl_ovf = 1'b0;
    mdl_unf = 1'b0;
  endfunction

  function automatic void mdl_write(input logic [2:0] a, input logic [31:0] d);
    if (a == 3'd0) begin
      if (mdl_q.size() < DEPTH) mdl_q.push_back(d);
      else                      mdl_ovf = 1'b1;
    end else if (a == 3'd3 && d[0]) begin
      mdl_clear();
    end
  endfunction

  function automatic void mdl_read(input logic [2:0] a);
    if (a == 3'd0) begin
      if (mdl_q.size() > 0) void'(mdl_q.pop_front());
      else                  mdl_unf = 1'b1;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tot_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
  endtask

  task automatic expect_rd(input string name, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  // Monitor: a qualified read presents data; otherwise readdata must be zero.
  always @(negedge clk) begin
    if (chipselect && read) begin
      if (!write) begin
        if (exp_q.size() == 0) begin
          tot_cnt++;
          $display("FAIL unexpected_read: got %h, expected no read (t=%0t)", readdata, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check(e.name, readdata, e.val);
        end
      end
    end else begin
      check("idle_zero", readdata, 32'd0);
    end
  end

  task automatic av_write(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; read = 1'b0; address = a; writedata = d;
    @(posedge clk);
    mdl_write(a, d);
    #1 chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic av_read(input logic [2:0] a, input string name);
    expect_rd(name, mdl_read_value(a));
    chipselect = 1'b1; write = 1'b0; read = 1'b1; address = a;
    @(posedge clk);
    mdl_read(a);
    #1 chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic av_both(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; read = 1'b1; address = a; writedata = d;
    @(posedge clk);
    mdl_write(a, d);
    #1 chipselect = 1'b0; write = 1'b0; read = 1'b0;
  endtask

  task automatic av_nocs(input logic [2:0] a, input logic [31:0] d, input logic r);
    chipselect = 1'b0; write = ~r; read = r; address = a; writedata = d;
    @(posedge clk);
    #1 write = 1'b0; read = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] words [4];
    words[0] = "abcd";
    words[1] = "1234";
    words[2] = "5678";
    words[3] = "BEEF";

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    av_read(3'd2, "count_after_reset");
    av_read(3'd1, "status_after_reset");

    for (int i = 0; i < 4; i++) begin
      av_write(3'd0, words[i]);
      av_read(3'd2, "count_after_push");
    end
    for (int i = 0; i < 4; i++) begin
      av_read(3'd0, "data_in_order");
      av_read(3'd2, "count_after_pop");
    end
    av_read(3'd1, "status_drained");

    for (int i = 0; i < 9; i++) av_write(3'd0, 32'(i));
    av_read(3'd2, "count_full");
    av_read(3'd1, "status_full_overflow");
    for (int i = 0; i < 8; i++) av_read(3'd0, "data_after_overflow");
    av_read(3'd2, "count_drained_again");

    av_write(3'd3, 32'd1);
    av_read(3'd0, "data_underflow");
    av_read(3'd2, "count_underflow");
    av_read(3'd1, "status_underflow");
    av_write(3'd3, 32'd1);
    av_read(3'd1, "status_after_flush");

    for (int i = 0; i < 3; i++) av_write(3'd0, 32'hA000_0000 + 32'(i));
    av_read(3'd2, "count_before_reset");
    // Reset lands in the middle of a write strobe and is held across the edge.
    chipselect = 1'b1; write = 1'b1; address = 3'd0; writedata = 32'hDEAD_BEEF;
    #2 reset = 1'b1;
    mdl_clear();
    #1 write = 1'b0; read = 1'b1; address = 3'd2;
    expect_rd("count_during_reset", 32'd0);
    @(posedge clk);
    #1 chipselect = 1'b0; read = 1'b0; reset = 1'b0;
    av_read(3'd1, "status_after_midreset");

    av_write(3'd0, 32'h1111_2222);
    av_nocs(3'd0, 32'h3333_4444, 1'b0);
    av_nocs(3'd0, 32'h5555_6666, 1'b1);
    av_nocs(3'd3, 32'h1, 1'b0);
    av_read(3'd2, "count_nocs");
    av_read(3'd5, "reserved_read");
    av_write(3'd5, 32'hFFFF_FFFF);
    av_read(3'd3, "ctrl_reads_zero");
    av_read(3'd2, "count_after_reserved_write");
    av_both(3'd0, 32'h7777_8888);
    av_read(3'd2, "count_write_priority");
    av_read(3'd0, "data_after_priority");
    av_read(3'd0, "data_priority_word");

    repeat (600) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 36)      av_write(3'd0, $urandom);
      else if (r < 64) av_read(3'd0, "rand_data");
      else if (r < 74) av_read(3'd1, "rand_status");
      else if (r < 84) av_read(3'd2, "rand_count");
      else if (r < 87) av_write(3'd3, 32'($urandom_range(0, 1)));
      else if (r < 91) av_read(3'($urandom_range(3, 7)), "rand_other_reg");
      else if (r < 94) av_write(3'($urandom_range(4, 7)), $urandom);
      else if (r < 97) av_nocs(3'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)));
      else             av_both(3'd0, $urandom);
    end
    av_read(3'd2, "final_count");
    av_read(3'd1, "final_status");

    repeat (2) @(posedge clk);
    check("expectations_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/string_hw_avalon.md
Name: string_hw_avalon

Overview:
- Avalon-MM slave word FIFO for the NIOS II string accelerator.
- Software pushes 32-bit words (4 packed ASCII chars) through a data register and pops them back in order through the same address.
- Occupancy and status are readable through separate registers.
- Sits on the Avalon system interconnect as a zero-wait-state, zero-read-latency slave.

Parameters:
- DEPTH, 8, number of 32-bit FIFO entries (power of 2, >=2)
- DATA_W, 32, word width (fixed by the Avalon data bus)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset; clears all state
- writedata  in  32  Avalon write data
- address  in  3  word address of register
- readdata  out  32  Avalon read data
- write  in  1  write strobe, one clock per access
- read  in  1  read strobe, one clock per access
- chipselect  in  1  slave select; write/read ignored when low

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high (ports clk, reset).
- Register map (word addresses):
  - 0 DATA: write pushes; read returns head and pops.
  - 1 STATUS (RO): bit0 empty, bit1 full, bit2 overflow (sticky), bit3 underflow (sticky); other bits 0.
  - 2 COUNT (RO): occupancy, zero-extended to 32 bits.
  - 3 CONTROL (WO): writedata bit0=1 flushes FIFO and clears sticky bits. Reads return 0.
  - 4-7: reserved; reads return 0, writes ignored.
- Access qualifiers: wr_en = chipselect & write; rd_en = chipselect & read.
- Read timing (zero latency):
  - readdata is combinational from address and current state while rd_en is high.
  - readdata = 0 when rd_en is low.
- Push: on the rising edge with wr_en & address==0 & !full.
  - mem[wr_ptr] <= writedata; wr_ptr++; count++.
- Pop: on the rising edge with rd_en & address==0 & !empty.
  - rd_ptr++; count--.
  - readdata showed mem[rd_ptr] during that cycle, so data is consumed exactly once per one-cycle read strobe.
- Strobe length: a strobe held N cycles performs N pushes or pops.
- Write when full: data is dropped, count is unchanged, overflow <= 1.
- Read of DATA when empty: readdata = 0, no pointer change, underflow <= 1.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH.
- count: log2(DEPTH)+1 bits, range 0..DEPTH. empty = (count==0); full = (count==DEPTH).
- write and read both asserted: write takes priority, read is ignored. Only one access per cycle; no simultaneous push/pop otherwise.
- Flush (CONTROL bit0): clears pointers, count and sticky bits on that edge. Memory contents need not be cleared.
- Reset (asynchronous, any time including mid-access):
  - wr_ptr, rd_ptr, count, overflow, underflow <= 0.
  - readdata follows the combinational rule; STATUS reads 0x1 after reset.
- chipselect low: no state change regardless of write/read.

Decomposition:
- Package string_hw_pkg:
  - register address constants ADDR_DATA=0, ADDR_STATUS=1, ADDR_COUNT=2, ADDR_CTRL=3
  - STATUS bit-index constants
  - CTRL_FLUSH bit index
- Sub-module string_word_fifo: synchronous FIFO (push, pop, flush, din, dout=head, count, empty, full, async reset).
- Top level: Avalon decode, read mux and sticky flags.

Test Plan:
- Reset, then read COUNT -> 0; read STATUS -> 0x1.
- Write DATA "abcd", "1234", "5678", "BEEF" (one cycle each) -> COUNT reads 1, 2, 3, 4 after each write.
- Four one-cycle DATA reads -> "abcd", "1234", "5678", "BEEF" in order; COUNT after each: 3, 2, 1, 0; STATUS then 0x1.
- Write 9 words 0..8 with DEPTH=8 -> COUNT 8, STATUS 0x6 (full + overflow); reads return 0..7; word 8 is lost.
- DATA read when empty -> readdata 0, COUNT stays 0, STATUS 0x9. Then write CONTROL=1 -> STATUS 0x1.
- Push 3 words, assert reset mid-write strobe -> COUNT 0 immediately. Write with chipselect=0 -> COUNT unchanged; reads of address 5 return 0.
